// File: rtl/clock_switch_ctrl.sv
// Select sequencer for the glitchless clock mux. It qualifies both lock
// indicators, runs requested switches with a lock timeout, and falls back automatically.
module clock_switch_ctrl #(
   parameter int unsigned LOCK_STABLE_CYCLES = 256,
   parameter int unsigned SETTLE_CYCLES      = 16,
   parameter int unsigned TIMEOUT_CYCLES     = 65536,
   parameter bit          FALLBACK_EN        = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   input  logic clk1_locked,
   input  logic clk2_locked,
   output logic sel,
   output logic clk1_stable,
   output logic clk2_stable,
   output logic busy,
   output logic done,
   output logic err,
   output logic fallback_evt
);

   localparam int unsigned LW = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_STABLE_CYCLES);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_LOCK,
      ST_SWITCH,
      ST_SETTLE
   } state_t;

   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    lock_s_c;
   logic [LW-1:0] lock_cnt_q [2];
   logic [LW-1:0] lock_cnt_d [2];
   logic [1:0]    stable_q;
   logic [1:0]    stable_d;

   state_t        state_q;
   logic          sel_q;
   logic          target_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic          fb_evt_q;
   logic [TW-1:0] tmo_q;
   logic [SW-1:0] settle_q;

   logic          idle_c;
   logic          fb_c;
   logic          accept_c;

   // Two-flop synchronizers for the asynchronous lock indicators
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {sync1_q[0], clk1_locked};
         sync2_q <= {sync2_q[0], clk2_locked};
      end
   end

   assign lock_s_c = {sync2_q[1], sync1_q[1]};

   // Per-source qualification: saturating count of consecutive synced-high cycles
   always_comb begin
      stable_d = '0;
      for (int i = 0; i < 2; i++) begin
         lock_cnt_d[i] = lock_cnt_q[i];
         if (!lock_s_c[i]) begin
            lock_cnt_d[i] = '0;
         end else if (lock_cnt_q[i] != LOCK_MAX) begin
            lock_cnt_d[i] = lock_cnt_q[i] + LW'(1);
         end
         stable_d[i] = (lock_cnt_d[i] == LOCK_MAX);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            lock_cnt_q[i] <= '0;
         end
         stable_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            lock_cnt_q[i] <= lock_cnt_d[i];
         end
         stable_q <= stable_d;
      end
   end

   // Fallback pre-empts any request presented in the same cycle
   assign idle_c    = (state_q == ST_IDLE);
   assign fb_c      = FALLBACK_EN && idle_c && !lock_s_c[sel_q] && stable_q[~sel_q];
   assign req_ready = idle_c && !fb_c;
   assign accept_c  = req_valid && req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         target_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         fb_evt_q <= 1'b0;
         tmo_q    <= '0;
         settle_q <= '0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         fb_evt_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fb_c) begin
                  target_q <= ~sel_q;
                  fb_evt_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ST_SWITCH;
               end else if (accept_c) begin
                  if (req_sel == sel_q) begin
                     done_q <= 1'b1;
                  end else begin
                     target_q <= req_sel;
                     tmo_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= ST_WAIT_LOCK;
                  end
               end
            end
            ST_WAIT_LOCK: begin
               if (stable_q[target_q]) begin
                  state_q <= ST_SWITCH;
               end else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            ST_SWITCH: begin
               sel_q    <= target_q;
               settle_q <= '0;
               state_q  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  settle_q <= settle_q + SW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sel          = sel_q;
   assign clk1_stable  = stable_q[0];
   assign clk2_stable  = stable_q[1];
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign fallback_evt = fb_evt_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Bench for clock_switch_ctrl: directed scenarios plus random lock/request traffic,
// all checked every cycle against a lock-history / phase-countdown reference model.
module tb_clock_switch_ctrl;

   localparam int unsigned LOCK_N   = 8;
   localparam int unsigned SETTLE_N = 4;
   localparam int unsigned TMO_N    = 32;

   localparam int P_IDLE = 0;
   localparam int P_WAIT = 1;
   localparam int P_SW   = 2;
   localparam int P_SET  = 3;

   logic clk = 1'b0;
   logic rst, req_valid, req_sel, clk1_locked, clk2_locked;
   logic req_ready, sel, clk1_stable, clk2_stable, busy, done, err, fallback_evt;

   always #5 clk = ~clk;

   clock_switch_ctrl #(
      .LOCK_STABLE_CYCLES (LOCK_N),
      .SETTLE_CYCLES      (SETTLE_N),
      .TIMEOUT_CYCLES     (TMO_N),
      .FALLBACK_EN        (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_sel      (req_sel),
      .req_ready    (req_ready),
      .clk1_locked  (clk1_locked),
      .clk2_locked  (clk2_locked),
      .sel          (sel),
      .clk1_stable  (clk1_stable),
      .clk2_stable  (clk2_stable),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .fallback_evt (fallback_evt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: h[k] is the lock input as sampled k edges ago (0 while in reset)
   bit [15:0] h1, h2;
   int        m_phase, m_wait, m_left;
   bit        m_sel, m_tgt, m_done, m_err, m_fbe, m_acc;

   function automatic bit stable_of(input bit [15:0] h);
      bit r = 1'b1;
      for (int i = 2; i < int'(LOCK_N) + 2; i++) r &= h[i];
      return r;
   endfunction

   function automatic bit fb_now();
      bit lk_act = m_sel ? h2[1] : h1[1];
      bit st_oth = m_sel ? stable_of(h1) : stable_of(h2);
      return (m_phase == P_IDLE) && !lk_act && st_oth;
   endfunction

   task automatic model_reset();
      h1 = '0; h2 = '0;
      m_phase = P_IDLE; m_wait = 0; m_left = 0;
      m_sel = 0; m_tgt = 0; m_done = 0; m_err = 0; m_fbe = 0; m_acc = 0;
   endtask

   task automatic model_edge();
      bit st_tgt = m_tgt ? stable_of(h2) : stable_of(h1);
      bit fb     = fb_now();
      bit rdy    = (m_phase == P_IDLE) && !fb;
      m_acc  = req_valid && rdy;
      m_done = 0; m_err = 0; m_fbe = 0;
      case (m_phase)
         P_IDLE: begin
            if (fb) begin
               m_tgt = !m_sel; m_fbe = 1; m_phase = P_SW;
            end else if (m_acc) begin
               if (req_sel == m_sel) m_done = 1;
               else begin m_tgt = req_sel; m_wait = 0; m_phase = P_WAIT; end
            end
         end
         P_WAIT: begin
            if (st_tgt) m_phase = P_SW;
            else begin
               m_wait++;
               if (m_wait == int'(TMO_N)) begin m_err = 1; m_phase = P_IDLE; end
            end
         end
         P_SW: begin
            m_sel = m_tgt; m_left = SETTLE_N; m_phase = P_SET;
         end
         default: begin
            m_left--;
            if (m_left == 0) begin m_done = 1; m_phase = P_IDLE; end
         end
      endcase
      h1 = {h1[14:0], bit'(clk1_locked)};
      h2 = {h2[14:0], bit'(clk2_locked)};
   endtask

   always @(posedge clk) begin
      if (rst) model_reset();
      else model_edge();
   end

   task automatic check_all();
      check_val("sel",          sel,          m_sel);
      check_val("busy",         busy,         m_phase != P_IDLE);
      check_val("done",         done,         m_done);
      check_val("err",          err,          m_err);
      check_val("fallback_evt", fallback_evt, m_fbe);
      check_val("clk1_stable",  clk1_stable,  stable_of(h1));
      check_val("clk2_stable",  clk2_stable,  stable_of(h2));
      check_val("req_ready",    req_ready,    (m_phase == P_IDLE) && !fb_now());
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic send_req(input bit s);
      req_valid = 1'b1;
      req_sel   = s;
      for (int i = 0; i < 64; i++) begin
         step();
         if (m_acc) break;
      end
      req_valid = 1'b0;
   endtask

   initial begin
      int t_a, t_b, dn1, dn2, rst_at;
      rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0;
      clk1_locked = 1'b1; clk2_locked = 1'b1;
      model_reset();
      #1;
      check_val("rst_sel", sel, 0);
      check_val("rst_busy", busy, 0);
      repeat (3) step();
      rst = 1'b0;

      // Stability qualification latency after reset release
      t_a = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (clk1_stable && t_a == 0) t_a = i + 1;
      end
      check_val("stable_latency", t_a, 10);

      // No-op request
      send_req(1'b0);
      check_val("noop_done", done, 1);
      check_val("noop_busy", busy, 0);
      repeat (2) step();

      // Normal switch to clk2 with latency measurement
      send_req(1'b1);
      t_a = 0; t_b = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (sel && t_a == 0) t_a = i + 1;
         if (done && t_b == 0) t_b = i + 1;
      end
      check_val("switch_sel_latency", t_a, 2);
      check_val("switch_done_latency", t_b, 2 + SETTLE_N);

      // Fallback on clk2 loss, with a request colliding with fb
      clk2_locked = 1'b0;
      repeat (2) step();
      check_val("fb_ready_low", req_ready, 0);
      req_valid = 1'b1; req_sel = 1'b1;
      step();
      check_val("fb_evt", fallback_evt, 1);
      step();
      check_val("fb_sel", sel, 0);
      for (int i = 0; i < 64 && !m_acc; i++) step();
      req_valid = 1'b0;

      // Held request now targets unlocked clk2: timeout
      t_a = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (err && t_a == 0) t_a = i + 1;
      end
      check_val("timeout_latency", t_a, TMO_N);
      check_val("timeout_sel", sel, 0);

      // Lock glitch during WAIT_LOCK restarts qualification
      send_req(1'b1);
      repeat (5) step();
      clk2_locked = 1'b1;
      repeat (5) step();
      clk2_locked = 1'b0;
      step();
      clk2_locked = 1'b1;
      repeat (30) step();
      check_val("glitch_sel", sel, 1);

      // Reset during SETTLE after a switch to clk2
      send_req(1'b0);
      repeat (8) step();
      send_req(1'b1);
      repeat (3) step();
      rst = 1'b1;
      model_reset();
      #1;
      check_val("midrst_sel", sel, 0);
      check_val("midrst_busy", busy, 0);
      check_all();
      repeat (4) step();
      rst = 1'b0;
      repeat (12) step();

      // Random lock outages, requests and one asynchronous reset
      dn1 = 0; dn2 = 0;
      rst_at = $urandom_range(150, 450);
      for (int c = 0; c < 600; c++) begin
         if (dn1 > 0) begin clk1_locked = 1'b0; dn1--; end
         else begin
            clk1_locked = 1'b1;
            if ($urandom_range(0, 23) == 0) dn1 = $urandom_range(1, 40);
         end
         if (dn2 > 0) begin clk2_locked = 1'b0; dn2--; end
         else begin
            clk2_locked = 1'b1;
            if ($urandom_range(0, 23) == 0) dn2 = $urandom_range(1, 40);
         end
         if (!req_valid && $urandom_range(0, 3) == 0) begin
            req_valid = 1'b1;
            req_sel   = 1'($urandom_range(0, 1));
         end
         if (c == rst_at) begin
            rst = 1'b1;
            req_valid = 1'b0;
            model_reset();
            #1;
            check_all();
         end
         if (c == rst_at + 2) rst = 1'b0;
         step();
         if (m_acc) req_valid = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
- Control-plane sequencer that drives the `sel` input of the downstream glitchless clock mux.
- Runs on the always-on reference clock and accepts switch requests from the command/register path through a valid/ready handshake.
- Before changing `sel`, it synchronizes and qualifies both clock-source lock indicators.
- Performs automatic fallback when the active source loses lock, and reports busy, done, error and fallback status.

Parameters:
- LOCK_STABLE_CYCLES, 256: consecutive cycles a synced lock must be high before that source counts as stable (≥1).
- SETTLE_CYCLES, 16: cycles held in SETTLE after `sel` changes, before done is reported (≥1).
- TIMEOUT_CYCLES, 65536: maximum cycles spent in WAIT_LOCK before the request is aborted (≥2).
- FALLBACK_EN, 1: 1 = automatic switch to the other source when the active source loses lock.

Ports:
- clk  in  1  always-on reference clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  switch request valid
- req_sel  in  1  requested source (0 = clk1, 1 = clk2)
- req_ready  out  1  request can be accepted this cycle
- clk1_locked  in  1  asynchronous lock indicator, source 1
- clk2_locked  in  1  asynchronous lock indicator, source 2
- sel  out  1  registered select to the clock mux
- clk1_stable  out  1  source 1 qualified stable
- clk2_stable  out  1  source 2 qualified stable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: switch or no-op request completed
- err  out  1  one-cycle pulse: WAIT_LOCK timeout
- fallback_evt  out  1  one-cycle pulse: automatic fallback started

Behaviour:
Clocking and reset:
- Single clock domain (`clk`); reset is asynchronous and active-high (`rst`).
- Reset values: sel=0, all status/pulse outputs 0, all counters 0, state=IDLE.
- Reset asserted mid-operation returns the block to IDLE and sets sel=0 immediately.

Lock qualification:
- Each locked input passes through a 2-flop synchronizer (reset 0).
- A per-source counter increments while the synced lock is high and clears to 0 when it is low.
- The counter saturates at LOCK_STABLE_CYCLES.
- clkN_stable = (counter == LOCK_STABLE_CYCLES), registered.
- Any low synced sample drops clkN_stable on the next cycle.

Fallback condition (fb):
- fb = FALLBACK_EN && IDLE && synced lock of the active source is low && the other source's stable flag is 1.

Handshake:
- req_ready = IDLE && !fb.
- A request is accepted on a cycle with req_valid && req_ready.
- fb has priority over a simultaneous request; that request is not accepted and the requester must hold it.

States:
- IDLE
  - If fb: target=~sel, pulse fallback_evt, go to SWITCH.
  - Else on accept with req_sel==sel: no-op; done pulses the next cycle and the state stays IDLE.
  - Else on accept: target=req_sel, clear the timeout counter, go to WAIT_LOCK.
- WAIT_LOCK
  - If target stable: go to SWITCH.
  - Else increment the timeout counter.
  - On reaching TIMEOUT_CYCLES: pulse err, return to IDLE, sel unchanged.
  - Lock loss here only resets the stability counter; the timeout keeps running.
- SWITCH (1 cycle)
  - sel<=target, clear the settle counter, go to SETTLE.
- SETTLE
  - Count SETTLE_CYCLES cycles, then pulse done and return to IDLE.
  - Target lock loss during SETTLE is ignored; it is handled by fb once back in IDLE.

Latency:
- With the target already stable: accept at edge E0, sel toggles at E2, done is high for the cycle after E(2+SETTLE_CYCLES).
- Fallback: sel toggles 1 edge after the edge where fallback_evt rises; done pulses after SETTLE as for a normal switch.

General rules:
- sel changes only in SWITCH.
- done, err and fallback_evt are mutually exclusive and never longer than 1 cycle.
- busy is 0 in IDLE and 1 in all other states.

Test Plan:
Bench parameters: LOCK_STABLE_CYCLES=8, SETTLE_CYCLES=4, TIMEOUT_CYCLES=32, FALLBACK_EN=1.
1. Reset: assert rst with both locks high → sel=0, busy=0, all pulses 0. Release rst → clk1_stable and clk2_stable rise exactly 10 cycles after the locks are seen (2 sync + 8 qualify).
2. Normal switch: both stable, send req_sel=1 → sel=1 two edges after accept, done 1-cycle pulse 4 cycles later, busy high throughout, req_ready low until done.
3. No-op: with sel=0, send req_sel=0 → sel stays 0, done pulses the next cycle, busy never rises.
4. Timeout: clk2_locked=0, send req_sel=1 → err pulses after 32 cycles in WAIT_LOCK, sel stays 0, state returns to IDLE. Also: a lock glitch during WAIT_LOCK restarts the 8-cycle qualification.
5. Fallback: sel=1, clk1 stable, drop clk2_locked → fallback_evt pulse, sel=0 on the next edge, done after settle. Also: req_valid in the same cycle as fb is not accepted (req_ready=0).
6. Mid-operation reset: assert rst during SETTLE after sel=1 → sel=0 and busy=0 asynchronously, with no done pulse.
